// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, types and helpers for the multi-port register file.
//   RF_XLEN / RF_NREGS / RF_PCNT_W : default data width, register count, pending-counter width
//   AW                             : address width for the default register count
//   RF_MAX_WR                      : widest write-port vector popcount() accepts
//   rf_addr_t / rf_data_t / pcnt_t : convenience types at the default sizes
//   popcount()                     : number of set bits, used for per-register release counts
package rf_pkg;

    localparam int unsigned RF_XLEN   = 32;
    localparam int unsigned RF_NREGS  = 32;
    localparam int unsigned RF_PCNT_W = 2;
    localparam int unsigned AW        = $clog2(RF_NREGS);
    localparam int unsigned RF_MAX_WR = 8;

    typedef logic [AW-1:0]        rf_addr_t;
    typedef logic [RF_XLEN-1:0]   rf_data_t;
    typedef logic [RF_PCNT_W-1:0] pcnt_t;

    function automatic int unsigned popcount(input logic [RF_MAX_WR-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(RF_MAX_WR); i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// rf_pend_ctr: pending-write counter for one architectural register.
//   clk, aresetn : clock, asynchronous active-low reset (counter clears to 0)
//   inc          : one reservation accepted for this register this cycle
//   dec          : number of write ports releasing this register this cycle
//   cnt          : registered pending count
//   sat          : counter at its maximum, further reservations must be refused
//   underflow    : more releases than pending + inc this cycle (count clamps to 0)
module rf_pend_ctr #(
    parameter int unsigned PCNT_W = 2,
    parameter int unsigned DEC_W  = 2
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              inc,
    input  logic [DEC_W-1:0]  dec,
    output logic [PCNT_W-1:0] cnt,
    output logic              sat,
    output logic              underflow
);

    logic [PCNT_W-1:0] cnt_q, cnt_d;
    int                sum;

    // Net change only: a reserve and a release in the same cycle never toggle busy.
    always_comb begin
        sum       = int'(cnt_q) + int'(inc) - int'(dec);
        underflow = 1'b0;
        cnt_d     = '0;
        if (sum < 0) begin
            underflow = 1'b1;
        end else begin
            cnt_d = sum[PCNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == '1);

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with an in-order write scoreboard.
//   clk, aresetn       : clock, asynchronous active-low reset
//   rd_addr/rd_data    : NRD combinational read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   rd_busy            : addressed register has at least one pending write
//   rsv_en/rsv_addr    : issue-side reservation of a destination register
//   rsv_ready          : 0 when the pending counter of rsv_addr is saturated
//   wr_en/addr/data    : NWR write ports; each write also releases one pending write
//   sb_err             : sticky, a release hit a register with nothing pending
// Register 0 reads as zero and is never reserved or busy.
// Build option RF_BYPASS_EN: same-cycle write data is forwarded to the read ports and
// rd_busy drops when the final pending write is landing this cycle.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN,
    parameter int unsigned NREGS  = RF_NREGS,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned PCNT_W = RF_PCNT_W,
    localparam int unsigned ADDR_W = $clog2(NREGS),
    localparam int unsigned DEC_W  = $clog2(NWR + 1)
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]    rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic                   rsv_ready,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*ADDR_W-1:0]  wr_addr,
    input  logic [NWR*XLEN-1:0]    wr_data,
    output logic                   sb_err
);

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [PCNT_W-1:0] pcnt   [NREGS];
    logic [DEC_W-1:0]  dec_cnt [NREGS];
    logic [NREGS-1:0]  sat;
    logic [NREGS-1:0]  uf;
    logic              rsv_fire;
    logic              sb_err_q;

    // Register 0 has no counter: never busy, never saturated, never underflows.
    assign pcnt[0]    = '0;
    assign dec_cnt[0] = '0;
    assign sat[0]     = 1'b0;
    assign uf[0]      = 1'b0;

    assign rsv_ready = ~sat[rsv_addr];
    assign rsv_fire  = rsv_en & rsv_ready;

    for (genvar r = 1; r < int'(NREGS); r++) begin : g_ctr
        logic [NWR-1:0] hit;

        always_comb begin
            hit = '0;
            for (int j = 0; j < int'(NWR); j++) begin
                hit[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r));
            end
        end

        assign dec_cnt[r] = DEC_W'(popcount(RF_MAX_WR'(hit)));

        rf_pend_ctr #(
            .PCNT_W (PCNT_W),
            .DEC_W  (DEC_W)
        ) u_ctr (
            .clk       (clk),
            .aresetn   (aresetn),
            .inc       (rsv_fire && (rsv_addr == ADDR_W'(r))),
            .dec       (dec_cnt[r]),
            .cnt       (pcnt[r]),
            .sat       (sat[r]),
            .underflow (uf[r])
        );
    end

    // Later ports overwrite earlier ones, so the highest port index wins a collision.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                    regs_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sb_err_q <= 1'b0;
        end else if (|uf) begin
            sb_err_q <= 1'b1;
        end
    end

    assign sb_err = sb_err_q;

    always_comb begin
        logic [ADDR_W-1:0] a;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            a = rd_addr[i*ADDR_W +: ADDR_W];
            rd_data[i*XLEN +: XLEN] = regs_q[a];
            rd_busy[i]              = (pcnt[a] != '0);
`ifdef RF_BYPASS_EN
            for (int j = 0; j < int'(NWR); j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a) && (a != '0)) begin
                    rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                end
            end
            // Last outstanding write lands now: the consumer may proceed this cycle.
            if (int'(pcnt[a]) == int'(dec_cnt[a])) begin
                rd_busy[i] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW = 5;
    localparam int PMAX = 3;

    logic                 clk;
    logic                 aresetn;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
    logic                 rsv_ready;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 sb_err;

    regfile_mp_sb dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sb_err    (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic                ready;
        logic                err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: architectural values, outstanding-write counts, sticky error.
    logic [XLEN-1:0] m_regs [NREGS];
    int              m_pend [NREGS];
    bit              m_err;

    function automatic int wa(int j);
        return int'(wr_addr[j*AW +: AW]);
    endfunction

    function automatic int ra(int i);
        return int'(rd_addr[i*AW +: AW]);
    endfunction

    function automatic int nrel(int r);
        int n = 0;
        for (int j = 0; j < NWR; j++) if (wr_en[j] && wa(j) == r) n++;
        return n;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.data = '0;
        e.busy = '0;
        for (int i = 0; i < NRD; i++) begin
            int a = ra(i);
            if (a != 0) begin
                e.data[i*XLEN +: XLEN] = m_regs[a];
                e.busy[i] = (m_pend[a] > 0);
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j] && wa(j) == a) e.data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                if (m_pend[a] == nrel(a)) e.busy[i] = 1'b0;
`endif
            end
        end
        e.ready = (rsv_addr == 0) || (m_pend[rsv_addr] < PMAX);
        e.err = m_err;
        return e;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void commit();
        bit ok = (rsv_addr == 0) || (m_pend[rsv_addr] < PMAX);
        for (int r = 1; r < NREGS; r++) begin
            int n = m_pend[r] - nrel(r);
            if (rsv_en && ok && rsv_addr == r) n++;
            if (n < 0) begin
                n = 0;
                m_err = 1'b1;
            end
            m_pend[r] = n;
        end
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wa(j) != 0) m_regs[wa(j)] = wr_data[j*XLEN +: XLEN];
    endfunction

    // Called at a falling edge with stimulus already applied.
    task automatic step();
        sbq.push_back(predict());
        @(posedge clk);
        if (aresetn) commit();
        @(negedge clk);
    endtask

    task automatic idle();
        rsv_en = 1'b0;
        rsv_addr = '0;
        wr_en = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
    endtask

    task automatic set_rd(int a0, int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic set_wr(int j, int a, logic [XLEN-1:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    // Asynchronous reset asserted mid-cycle, held one sampled cycle, released at a falling edge.
    task automatic reset_pulse();
        #3;
        aresetn = 1'b0;
        model_clear();
        @(negedge clk);
        step();
        aresetn = 1'b1;
    endtask

    task automatic cmp(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: the read side is always presenting; sample mid-low-phase after each drive.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < NRD; i++)
                    cmp($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]),
                        64'(e.data[i*XLEN +: XLEN]));
                cmp("rd_busy", 64'(rd_busy), 64'(e.busy));
                cmp("rsv_ready", 64'(rsv_ready), 64'(e.ready));
                cmp("sb_err", 64'(sb_err), 64'(e.err));
            end
        end
    end

    function automatic int pick_addr();
        int cand[$];
        for (int r = 1; r < NREGS; r++) if (m_pend[r] > 0) cand.push_back(r);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            return cand[$urandom_range(0, cand.size() - 1)];
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
    endfunction

    initial begin
        aresetn = 1'b0;
        model_clear();
        idle();
        @(negedge clk);

        // Reset state seen on every address of every port.
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            rsv_addr = AW'(a);
            step();
        end
        aresetn = 1'b1;
        idle();
        step();

        // Single write then read; write to r0 is discarded.
        set_wr(0, 5, 32'hDEADBEEF);
        step();
        idle();
        set_rd(5, 0);
        step();
        set_wr(0, 0, 32'hFFFFFFFF);
        step();
        idle();
        set_rd(0, 5);
        step();

        // Port collision: highest port wins.
        set_wr(0, 7, 32'h1111);
        set_wr(1, 7, 32'h2222);
        step();
        idle();
        set_rd(7, 7);
        step();
        reset_pulse();

        // Saturate r3, refuse the 4th reserve, then drain.
        idle();
        rsv_en = 1'b1;
        rsv_addr = AW'(3);
        set_rd(3, 7);
        repeat (4) step();
        rsv_en = 1'b0;
        set_wr(0, 3, 32'h33);
        step();
        idle();
        rsv_addr = AW'(3);
        set_rd(3, 3);
        step();
        set_wr(0, 3, 32'h34);
        set_wr(1, 3, 32'h35);
        step();
        idle();
        set_rd(3, 0);
        step();

        // Reserve and release r9 in one cycle; then a stray write to r4.
        rsv_en = 1'b1;
        rsv_addr = AW'(9);
        set_rd(9, 4);
        step();
        set_wr(1, 9, 32'h99);
        step();
        idle();
        set_rd(9, 4);
        step();
        set_wr(0, 4, 32'h44);
        set_rd(4, 9);
        step();
        idle();
        set_rd(9, 4);
        repeat (2) step();

        // Reset mid-flight with r3 pending, then same-cycle read of a write.
        rsv_en = 1'b1;
        rsv_addr = AW'(3);
        set_rd(3, 3);
        step();
        idle();
        set_rd(3, 0);
        reset_pulse();
        idle();
        set_rd(3, 6);
        step();
        set_wr(0, 6, 32'h5A);
        step();
        idle();
        set_wr(1, 6, 32'hA5);
        set_rd(6, 6);
        step();
        idle();
        set_rd(6, 0);
        step();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            idle();
            rsv_en = ($urandom_range(0, 2) != 0);
            rsv_addr = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 2) == 0) set_wr(j, pick_addr(), $urandom());
            set_rd(pick_addr(), pick_addr());
            if ($urandom_range(0, 149) == 0) reset_pulse();
            else step();
        end

        idle();
        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0 pending expectations", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
